// File: rtl/apb_led_pkg.sv
// Shared definitions for the APB LED peripheral: register offsets,
// CTRL bit positions and the APB transfer state encoding.
package apb_led_pkg;

   // Register byte offsets within the peripheral window (paddr[4:0])
   localparam logic [4:0] OFF_CTRL    = 5'h00;
   localparam logic [4:0] OFF_PATTERN = 5'h04;
   localparam logic [4:0] OFF_PERIOD  = 5'h08;
   localparam logic [4:0] OFF_STATUS  = 5'h0C;
   localparam logic [4:0] OFF_SCRATCH = 5'h10;

   // CTRL bit indices
   localparam int unsigned CTRL_EN    = 0;
   localparam int unsigned CTRL_BLINK = 1;
   localparam int unsigned CTRL_W     = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/led_blink_gen.sv
// Blink phase generator: counts pclk cycles and toggles phase every
// period cycles while blinking is enabled.
// Ports:
//   pclk, presetn : clock, async active-low reset
//   run           : EN & BLINK; when low the counter is cleared and phase forced to 1
//   period        : half-period in pclk cycles; 0 freezes counter and phase
//   clr           : committed write to CTRL/PERIOD; restarts the count, phase held
//   phase         : current blink phase (1 = LEDs on)
module led_blink_gen (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        run,
   input  logic [31:0] period,
   input  logic        clr,
   output logic        phase
);

   logic [31:0] cnt;

   // Counter and phase; disable beats clear, clear beats wrap/toggle
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (!run) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (clr) begin
         cnt <= '0;
      end else if (period != 32'd0) begin
         if (cnt == period - 32'd1) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 32'd1;
         end
      end
   end

endmodule

// File: rtl/apb_led_slave.sv
// APB responder for the LED peripheral: small register file, setup/access
// sequencing with WAIT_CYCLES wait states, error response and LED drive
// (static pattern or blinking).
// Ports:
//   pclk, presetn                 : clock, async active-low reset
//   paddr, psel, penable, pwrite  : APB request
//   pwdata, pstrb                 : APB write data and byte strobes
//   pready_o, prdata_o, pslverr_o : APB completion, read data, error
//   led_o                         : LED drive, active-high (registered)
module apb_led_slave
   import apb_led_pkg::*;
#(
   parameter int unsigned PADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned LED_NUM     = 8,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic [PADDR_WIDTH-1:0]  paddr,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready_o,
   output logic [DATA_WIDTH-1:0]   prdata_o,
   output logic                    pslverr_o,
   output logic [LED_NUM-1:0]      led_o
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned WCNT_W = 4;

   state_t                 state;
   logic [WCNT_W-1:0]      wait_cnt;

   logic [CTRL_W-1:0]      ctrl;
   logic [LED_NUM-1:0]     pattern;
   logic [DATA_WIDTH-1:0]  period;
   logic [DATA_WIDTH-1:0]  scratch;
   logic                   phase;

   logic [4:0]             offset;
   logic                   hi_nz;
   logic                   bad_addr;
   logic                   is_status;
   logic                   commit;
   logic                   blink_run;
   logic                   blink_clr;
   logic [DATA_WIDTH-1:0]  wmask;
   logic [DATA_WIDTH-1:0]  rdata;

   // Byte lanes are ignored in the decode
   logic unused_lanes;
   assign unused_lanes = &{1'b0, paddr[1:0]};

   assign offset = {paddr[4:2], 2'b00};

   // Any address bit above the 32-byte register window makes the access illegal
   if (PADDR_WIDTH > 5) begin : g_hi
      assign hi_nz = |paddr[PADDR_WIDTH-1:5];
   end else begin : g_nohi
      assign hi_nz = 1'b0;
   end

   assign bad_addr  = hi_nz | (offset > OFF_SCRATCH);
   assign is_status = (offset == OFF_STATUS);

   assign pready_o  = (state == ACCESS) & psel & penable & (wait_cnt == '0);
   assign pslverr_o = pready_o & (bad_addr | (pwrite & is_status));
   assign commit    = pready_o & pwrite & ~pslverr_o;

   // Per-byte write mask from the strobes
   always_comb begin
      wmask = '0;
      for (int unsigned i = 0; i < STRB_W; i++) begin
         wmask[i*8 +: 8] = {8{pstrb[i]}};
      end
   end

   // Read mux
   always_comb begin
      rdata = '0;
      unique case (offset)
         OFF_CTRL:    rdata = DATA_WIDTH'(ctrl);
         OFF_PATTERN: rdata = DATA_WIDTH'(pattern);
         OFF_PERIOD:  rdata = period;
         OFF_STATUS:  rdata = DATA_WIDTH'({blink_run, phase});
         OFF_SCRATCH: rdata = scratch;
         default:     rdata = '0;
      endcase
   end

   assign prdata_o = (pready_o & ~pwrite & ~bad_addr) ? rdata : '0;

   // Transfer FSM: setup -> access (with wait states) -> idle
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (psel && !penable) begin
                  state    <= ACCESS;
                  wait_cnt <= WCNT_W'(WAIT_CYCLES);
               end
            end
            ACCESS: begin
               if (!psel || pready_o) begin
                  state <= IDLE;
               end else if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - WCNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Register file; only byte lanes enabled by pstrb are updated
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ctrl    <= '0;
         pattern <= '0;
         period  <= '0;
         scratch <= '0;
      end else if (commit) begin
         unique case (offset)
            OFF_CTRL:    ctrl    <= (ctrl & ~wmask[CTRL_W-1:0]) | (pwdata[CTRL_W-1:0] & wmask[CTRL_W-1:0]);
            OFF_PATTERN: pattern <= (pattern & ~wmask[LED_NUM-1:0]) | (pwdata[LED_NUM-1:0] & wmask[LED_NUM-1:0]);
            OFF_PERIOD:  period  <= (period & ~wmask) | (pwdata & wmask);
            OFF_SCRATCH: scratch <= (scratch & ~wmask) | (pwdata & wmask);
            default: ;
         endcase
      end
   end

   assign blink_run = ctrl[CTRL_EN] & ctrl[CTRL_BLINK];
   assign blink_clr = commit & ((offset == OFF_CTRL) | (offset == OFF_PERIOD));

   led_blink_gen u_blink (
      .pclk    (pclk),
      .presetn (presetn),
      .run     (blink_run),
      .period  (period),
      .clr     (blink_clr),
      .phase   (phase)
   );

   // LED drive
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         led_o <= '0;
      end else if (!ctrl[CTRL_EN]) begin
         led_o <= '0;
      end else if (!ctrl[CTRL_BLINK]) begin
         led_o <= pattern;
      end else begin
         led_o <= phase ? pattern : '0;
      end
   end

endmodule
